design_select_ctrl: RTL and testbench
=====================================

# design_select_ctrl

Wishbone-controlled design selector that sits directly upstream of the per-design reset synchronizers. It holds the selected design ID (1..12, 0 = none), drives the `designs_cs[12:1]` hold-in-reset mask consumed by the reset router, and drives the one-hot `design_en[12:1]` used by the IO mux. Every change of selection is sequenced: first all designs are held, then the hold is kept for a fixed interval, and only then is the newly selected design released.

## Interface
Parameters:
- `NUM_DESIGNS`, 12: number of designs; sets the width of `designs_cs` and `design_en`.
- `HOLD_CYCLES`, 16: clk cycles during which all designs are held on a switchover; must be ≥ 2.

Ports:
- `clk` in 1: clock.
- `asyncrst_n` in 1: reset, asynchronous, active-low.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 4: byte address; only bits [3:2] are decoded.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `designs_cs` out NUM_DESIGNS: bit i = 1 holds design i in reset.
- `design_en` out NUM_DESIGNS: one-hot IO-mux enable of the active design.
- `busy` out 1: switchover in progress.

## Operation
Register map (word offsets):
- 0x0 SEL (RW): [3:0] is the pending ID. A read returns the pending ID.
- 0x4 STATUS (RO):
  - [3:0] active ID.
  - [8] busy.
  - [9] bad_id: sticky; set by a write of an ID > NUM_DESIGNS; cleared by any read of STATUS.
- 0x8 CTRL: behaviour defined under Configuration; reads 0.
- Unmapped addresses: writes are ignored, reads return 0, ack is still given.
- A written ID > NUM_DESIGNS is stored as 0 and sets bad_id.

Acknowledge:
- `wb_ack_o` is registered: it is 1 in the cycle after `cyc & stb & ~ack`.
- A held strobe therefore produces ack on every other cycle.

FSM states:
- IDLE:
  - `designs_cs = ~onehot(active)`, where ID 0 gives all ones.
  - `design_en = onehot(active)`, where ID 0 gives all zeros.
- HOLD:
  - `designs_cs` = all ones, `design_en` = 0, `busy` = 1.
  - Down-counter `cnt` (width $clog2(HOLD_CYCLES)).

Transitions:
- IDLE → HOLD: a SEL write whose ID differs from `active`. `cnt` loads HOLD_CYCLES-1.
- A SEL write in IDLE whose ID equals `active` is a no-op apart from the ack.
- HOLD → HOLD: a SEL write while in HOLD updates the pending ID and reloads `cnt` to HOLD_CYCLES-1, restarting the hold.
- HOLD → IDLE: when `cnt == 0`, `active` ← pending.

## Timing
Reset values:
- `designs_cs` = all ones.
- `design_en` = 0.
- `busy` = 0.
- `wb_ack_o` = 0.
- `wb_dat_o` = 0.
- Active and pending IDs = 0; `cnt` = 0; FSM in IDLE; bad_id = 0.

Switchover timing:
- Let E0 be the clock edge at which `wb_ack_o` for a qualifying write rises.
- After E0, `designs_cs` is all ones, `design_en` is 0 and `busy` is 1.
- At edge E0+HOLD_CYCLES the new values appear and `busy` falls.
- All outputs are registered; there are no combinational paths from the bus to the outputs.
- The downstream reset synchronizer adds 2 cycles before the design leaves reset.

Boundary conditions:
- `asyncrst_n` low mid-HOLD: all state returns to reset values immediately.
- A write in the same cycle that `cnt` reaches 0: the write wins. The FSM stays in HOLD with `cnt` reloaded, and `active` is not updated.

## Configuration
- `DESIGN_SEL_SOFT_RST_EN` defined:
  - Writing CTRL with bit 0 = 1 while in IDLE with `active` ≠ 0 enters HOLD with pending = active, re-resetting the current design.
  - Such a write is ignored while in HOLD (ack is still given).
- Not defined:
  - CTRL writes are ignored.
  - No extra logic is generated.

## Test plan
- Reset, then read STATUS → 0x0; `designs_cs` = 0xFFF; `design_en` = 0x000.
- Write SEL = 5 →
  - `busy` = 1 and `designs_cs` = 0xFFF for exactly 16 cycles after ack;
  - then `designs_cs` = 0xFEF, `design_en` = 0x010, STATUS = 0x005.
- With active = 5, write SEL = 5 → no HOLD; outputs unchanged.
- Write SEL = 3, then SEL = 9 eight cycles later → hold extends to 16 cycles after the second ack; end state `design_en` = 0x100; design 3 is never enabled.
- Write SEL = 14 →
  - active becomes 0 after the hold; `designs_cs` = 0xFFF;
  - STATUS reads 0x200; a second STATUS read returns 0x000.
- With `DESIGN_SEL_SOFT_RST_EN`, active = 7, write CTRL = 1 → `designs_cs` = 0xFFF for 16 cycles, then 0xFBF. Assert `asyncrst_n` mid-hold → `designs_cs` = 0xFFF, `busy` = 0, active = 0.

Source files
------------

// File: rtl/design_select_ctrl.sv
// Wishbone design selector: sequences hold-in-reset masks and one-hot IO enables on every switchover.
// Optional soft re-reset of the active design via CTRL when DESIGN_SEL_SOFT_RST_EN is defined.
module design_select_ctrl #(
    parameter int unsigned NUM_DESIGNS = 12,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   asyncrst_n,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic [NUM_DESIGNS:1]   designs_cs,
    output logic [NUM_DESIGNS:1]   design_en,
    output logic                   busy
);

    localparam int unsigned ID_W     = 4;
    localparam int unsigned CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]        r_active, w_active_nxt;
    logic [ID_W-1:0]        r_pending, w_pending_nxt;
    logic                   r_bad_id, w_bad_id_nxt;
    logic                   r_ack;
    logic [31:0]            r_dat, w_dat_nxt;
    logic [NUM_DESIGNS:1]   r_cs, w_cs_nxt;
    logic [NUM_DESIGNS:1]   r_en, w_en_nxt;
    logic                   r_busy, w_busy_nxt;

    logic                   w_acc, w_wr, w_rd, w_sel_wr, w_stat_rd;
    logic [ID_W-1:0]        w_id_raw, w_id;
    logic                   w_id_bad;
    logic                   w_unused;

    // Bus decode; an access is accepted in the cycle before its ack
    assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr      = w_acc & wb_we_i;
    assign w_rd      = w_acc & ~wb_we_i;
    assign w_sel_wr  = w_wr & (wb_adr_i[3:2] == 2'd0);
    assign w_stat_rd = w_rd & (wb_adr_i[3:2] == 2'd1);
    assign w_id_raw  = wb_dat_i[ID_W-1:0];
    assign w_id_bad  = 32'(w_id_raw) > NUM_DESIGNS;
    assign w_id      = w_id_bad ? '0 : w_id_raw;
    assign w_unused  = ^{wb_dat_i[31:ID_W], wb_adr_i[1:0]};

`ifdef DESIGN_SEL_SOFT_RST_EN
    logic w_ctrl_wr;
    assign w_ctrl_wr = w_wr & (wb_adr_i[3:2] == 2'd2) & wb_dat_i[0];
`endif

    // Next-state, counter, ID and output computation
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_bad_id_nxt  = r_bad_id;
        w_dat_nxt     = '0;
        w_cs_nxt      = '1;
        w_en_nxt      = '0;
        w_busy_nxt    = 1'b0;

        if (w_stat_rd)
            w_bad_id_nxt = 1'b0;
        if (w_sel_wr && w_id_bad)
            w_bad_id_nxt = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_wr) begin
                    w_pending_nxt = w_id;
                    if (w_id != r_active) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
`ifdef DESIGN_SEL_SOFT_RST_EN
                else if (w_ctrl_wr && (r_active != '0)) begin
                    w_state_nxt   = ST_HOLD;
                    w_pending_nxt = r_active;
                    w_cnt_nxt     = CNT_LOAD;
                end
`endif
            end
            ST_HOLD: begin
                // A write landing on the final count restarts the hold
                if (w_sel_wr) begin
                    w_pending_nxt = w_id;
                    w_cnt_nxt     = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = r_pending;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_HOLD) begin
            w_busy_nxt = 1'b1;
        end else begin
            for (int i = 1; i <= int'(NUM_DESIGNS); i++)
                w_en_nxt[i] = (w_active_nxt == ID_W'(i));
            w_cs_nxt = ~w_en_nxt;
        end

        if (w_rd) begin
            case (wb_adr_i[3:2])
                2'd0:    w_dat_nxt = 32'(r_pending);
                2'd1:    w_dat_nxt = {22'd0, r_bad_id, r_busy, 4'd0, r_active};
                default: w_dat_nxt = '0;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_active  <= '0;
            r_pending <= '0;
            r_bad_id  <= 1'b0;
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_cs      <= '1;
            r_en      <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_bad_id  <= w_bad_id_nxt;
            r_ack     <= w_acc;
            r_dat     <= w_dat_nxt;
            r_cs      <= w_cs_nxt;
            r_en      <= w_en_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign wb_dat_o   = r_dat;
    assign wb_ack_o   = r_ack;
    assign designs_cs = r_cs;
    assign design_en  = r_en;
    assign busy       = r_busy;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed self-checking bench for design_select_ctrl (NUM_DESIGNS=12, HOLD_CYCLES=16).
module tb_design_select_ctrl;

    logic        clk = 1'b0;
    logic        asyncrst_n = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [12:1] designs_cs;
    logic [12:1] design_en;
    logic        busy;

    int          n_checks = 0;
    int          n_fails = 0;
    logic [11:0] saw_mask = '0;
    logic [31:0] rd;
    int          n;

    design_select_ctrl #(.NUM_DESIGNS(12), .HOLD_CYCLES(16)) dut (
        .clk(clk), .asyncrst_n(asyncrst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .designs_cs(designs_cs), .design_en(design_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock, sampled 1ns after the edge; records every enable seen
    task automatic tick();
        @(posedge clk);
        #1;
        saw_mask = saw_mask | design_en;
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        while (!wb_ack_o && k < 8) begin
            tick();
            k++;
        end
        if (!wb_ack_o) check({tag, "_ack_timeout"}, 32'(wb_ack_o), 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr;  wb_dat_i = dat;
        tick();
        wait_ack("wr");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = adr;
        tick();
        wait_ack("rd");
        dat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    // Count sampled cycles with busy high, starting at the current sample
    task automatic measure_hold(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        #23;
        check("rst_cs",   32'(designs_cs), 32'h0FFF);
        check("rst_en",   32'(design_en),  32'h0000);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_ack",  32'(wb_ack_o),   32'd0);
        check("rst_dat",  wb_dat_o,        32'h0);
        asyncrst_n = 1'b1;
        tick();
        wb_read(4'h4, rd);
        check("rst_status", rd, 32'h0);

        // First selection
        wb_write(4'h0, 32'd5);
        check("sel5_cs_hold", 32'(designs_cs), 32'h0FFF);
        measure_hold(n);
        check("sel5_hold_len", 32'(n), 32'd16);
        check("sel5_cs", 32'(designs_cs), 32'h0FEF);
        check("sel5_en", 32'(design_en),  32'h0010);
        wb_read(4'h4, rd);
        check("sel5_status", rd, 32'h005);
        wb_read(4'h0, rd);
        check("sel5_readback", rd, 32'h005);

        // Same ID is a no-op
        wb_write(4'h0, 32'd5);
        check("same_busy", 32'(busy), 32'd0);
        tick(); tick();
        check("same_cs", 32'(designs_cs), 32'h0FEF);
        check("same_en", 32'(design_en),  32'h0010);

        // Retarget mid-hold: 3 then 9 eight cycles later
        wb_write(4'h0, 32'd3);
        saw_mask = '0;
        repeat (7) tick();
        wb_write(4'h0, 32'd9);
        measure_hold(n);
        check("retgt_hold_len", 32'(n), 32'd16);
        check("retgt_en", 32'(design_en), 32'h0100);
        check("retgt_saw", 32'(saw_mask), 32'h0100);

        // Write on the final hold cycle wins over the release
        wb_write(4'h0, 32'd2);
        saw_mask = '0;
        repeat (15) tick();
        wb_write(4'h0, 32'd4);
        check("edge_busy", 32'(busy), 32'd1);
        check("edge_en", 32'(design_en), 32'h0);
        measure_hold(n);
        check("edge_hold_len", 32'(n), 32'd16);
        check("edge_en_final", 32'(design_en), 32'h0008);
        check("edge_saw", 32'(saw_mask), 32'h0008);

        // Out-of-range ID: stored as 0, bad_id sticky until STATUS read
        wb_write(4'h0, 32'd14);
        measure_hold(n);
        check("bad_hold_len", 32'(n), 32'd16);
        check("bad_cs", 32'(designs_cs), 32'h0FFF);
        check("bad_en", 32'(design_en),  32'h0);
        wb_read(4'h0, rd);
        check("bad_sel_rd", rd, 32'h0);
        wb_read(4'h4, rd);
        check("bad_status1", rd, 32'h200);
        wb_read(4'h4, rd);
        check("bad_status2", rd, 32'h000);

        // Unmapped / CTRL reads return 0; unmapped write ignored
        wb_read(4'hC, rd);
        check("unmapped_rd", rd, 32'h0);
        wb_read(4'h8, rd);
        check("ctrl_rd", rd, 32'h0);
        wb_write(4'hC, 32'd7);
        check("unmapped_wr_busy", 32'(busy), 32'd0);

        // Select 7 for the CTRL scenarios
        wb_write(4'h0, 32'd7);
        measure_hold(n);
        check("sel7_hold_len", 32'(n), 32'd16);
        check("sel7_cs", 32'(designs_cs), 32'h0FBF);
        wb_write(4'h8, 32'd1);
`ifdef DESIGN_SEL_SOFT_RST_EN
        check("soft_cs_hold", 32'(designs_cs), 32'h0FFF);
        measure_hold(n);
        check("soft_hold_len", 32'(n), 32'd16);
        check("soft_cs", 32'(designs_cs), 32'h0FBF);
        wb_write(4'h8, 32'd1);
        repeat (5) tick();
        wb_write(4'h8, 32'd1);
        measure_hold(n);
        check("soft_inhold_len", 32'(n), 32'd10);
`else
        check("ctrl_ign_busy", 32'(busy), 32'd0);
        check("ctrl_ign_cs", 32'(designs_cs), 32'h0FBF);
`endif

        // Asynchronous reset in the middle of a hold
        wb_write(4'h0, 32'd3);
        repeat (5) tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        #2 asyncrst_n = 1'b0;
        #1;
        check("arst_cs",   32'(designs_cs), 32'h0FFF);
        check("arst_busy", 32'(busy),       32'd0);
        check("arst_en",   32'(design_en),  32'h0);
        tick();
        asyncrst_n = 1'b1;
        tick();
        wb_read(4'h4, rd);
        check("arst_status", rd, 32'h0);
        wb_read(4'h0, rd);
        check("arst_pending", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
